// File: rtl/spgemm_pkg.sv
// Shared types and defaults for the CSR SpGEMM engine.
package spgemm_pkg;
  localparam int DATA_W_D   = 32;
  localparam int NNZ_MAX_D  = 16;
  localparam int ROWS_MAX_D = 16;
  localparam int IDX_W_D    = $clog2(NNZ_MAX_D + 1);

  typedef logic [DATA_W_D-1:0] data_t;
  typedef logic [IDX_W_D-1:0]  idx_t;

  typedef enum logic [2:0] {
    IDLE,
    ROW,
    AELEM,
    SEARCH,
    ROWEND,
    DONE
  } state_t;
endpackage

// File: rtl/csr_row_insert.sv
// Combinational shift-and-insert of one (value, column) pair at position i_pos;
// entries at and above i_pos move up one slot, the top slot falls off.
module csr_row_insert
  import spgemm_pkg::*;
#(
  parameter int DATA_W  = DATA_W_D,
  parameter int NNZ_MAX = NNZ_MAX_D,
  parameter int IDX_W   = $clog2(NNZ_MAX + 1)
) (
  input  logic [NNZ_MAX-1:0][DATA_W-1:0] i_nv,
  input  logic [NNZ_MAX-1:0][IDX_W-1:0]  i_ci,
  input  logic [IDX_W-1:0]               i_pos,
  input  logic [DATA_W-1:0]              i_val,
  input  logic [IDX_W-1:0]               i_col,
  output logic [NNZ_MAX-1:0][DATA_W-1:0] o_nv,
  output logic [NNZ_MAX-1:0][IDX_W-1:0]  o_ci
);
  for (genvar g = 0; g < NNZ_MAX; g++) begin : g_lane
    if (g == 0) begin : g_first
      assign o_nv[g] = (i_pos == '0) ? i_val : i_nv[g];
      assign o_ci[g] = (i_pos == '0) ? i_col : i_ci[g];
    end else begin : g_rest
      always_comb begin
        o_nv[g] = i_nv[g];
        o_ci[g] = i_ci[g];
        if (IDX_W'(g) == i_pos) begin
          o_nv[g] = i_val;
          o_ci[g] = i_col;
        end else if (IDX_W'(g) > i_pos) begin
          o_nv[g] = i_nv[g-1];
          o_ci[g] = i_ci[g-1];
        end
      end
    end
  end
endmodule

// File: rtl/csr_spgemm_engine.sv
// Row-wise (Gustavson) CSR sparse matrix multiply C = A x B, one compare per cycle.
// Define SPGEMM_SAT_EN for saturating arithmetic and the sticky sat_o flag.
module csr_spgemm_engine
  import spgemm_pkg::*;
#(
  parameter int DATA_W   = DATA_W_D,
  parameter int NNZ_MAX  = NNZ_MAX_D,
  parameter int ROWS_MAX = ROWS_MAX_D,
  parameter int IDX_W    = $clog2(NNZ_MAX + 1)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          start_i,
  input  logic [IDX_W-1:0]              n_rows_i,
  input  logic [NNZ_MAX*DATA_W-1:0]     nva_i,
  input  logic [NNZ_MAX*DATA_W-1:0]     nvb_i,
  input  logic [NNZ_MAX*IDX_W-1:0]      cia_i,
  input  logic [NNZ_MAX*IDX_W-1:0]      cib_i,
  input  logic [(ROWS_MAX+1)*IDX_W-1:0] rpa_i,
  input  logic [(ROWS_MAX+1)*IDX_W-1:0] rpb_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic [NNZ_MAX*DATA_W-1:0]     nvc_o,
  output logic [NNZ_MAX*IDX_W-1:0]      cic_o,
  output logic [(ROWS_MAX+1)*IDX_W-1:0] rpc_o,
  output logic [IDX_W-1:0]              nnz_c_o,
  output logic                          overflow_o
`ifdef SPGEMM_SAT_EN
  ,
  output logic                          sat_o
`endif
);
  localparam int NW = $clog2(NNZ_MAX);
  localparam int RW = $clog2(ROWS_MAX + 1);
  localparam logic [IDX_W-1:0] I1 = IDX_W'(1);

  state_t r_state, w_nxt;

  logic [NNZ_MAX-1:0][DATA_W-1:0] r_nva, r_nvb, r_nvc;
  logic [NNZ_MAX-1:0][IDX_W-1:0]  r_cia, r_cib, r_cic;
  logic [ROWS_MAX:0][IDX_W-1:0]   r_rpa, r_rpb, r_rpc;
  logic [IDX_W-1:0] r_nrows, r_r, r_k, r_aend, r_m, r_mend, r_s, r_nnz;
  logic             r_ovf;

  logic [IDX_W-1:0]  w_j, w_c, w_ci, w_rp_lo, w_rp_hi, w_bp_lo, w_bp_hi;
  logic [DATA_W-1:0] w_a, w_b, w_p, w_nv, w_acc;
  logic w_accept, w_search, w_zero, w_tail, w_lt, w_eq, w_full;
  logic w_fwd, w_adv_m, w_acc_en, w_ins_en, w_place, w_m_last, w_k_last;
  logic [NNZ_MAX-1:0][DATA_W-1:0] w_ins_nv;
  logic [NNZ_MAX-1:0][IDX_W-1:0]  w_ins_ci;

  // Operand fetch: current A row bounds, current A element, current B element.
  assign w_rp_lo = r_rpa[RW'(r_r)];
  assign w_rp_hi = r_rpa[RW'(r_r + I1)];
  assign w_j     = r_cia[NW'(r_k)];
  assign w_a     = r_nva[NW'(r_k)];
  assign w_bp_lo = r_rpb[RW'(w_j)];
  assign w_bp_hi = r_rpb[RW'(w_j + I1)];
  assign w_b     = r_nvb[NW'(r_m)];
  assign w_c     = r_cib[NW'(r_m)];
  assign w_nv    = r_nvc[NW'(r_s)];
  assign w_ci    = r_cic[NW'(r_s)];

`ifdef SPGEMM_SAT_EN
  logic [2*DATA_W-1:0] w_prod;
  logic [DATA_W:0]     w_sum;
  logic                w_psat, w_asat, r_sat;
  assign w_prod = {{DATA_W{1'b0}}, w_a} * {{DATA_W{1'b0}}, w_b};
  assign w_psat = |w_prod[2*DATA_W-1:DATA_W];
  assign w_p    = w_psat ? '1 : w_prod[DATA_W-1:0];
  assign w_sum  = {1'b0, w_nv} + {1'b0, w_p};
  assign w_asat = w_sum[DATA_W];
  assign w_acc  = w_asat ? '1 : w_sum[DATA_W-1:0];
  assign sat_o  = r_sat;
`else
  assign w_p   = w_a * w_b;
  assign w_acc = w_nv + w_p;
`endif

  // SEARCH decode; s only moves forward within one B row since B rows are sorted.
  assign w_accept = start_i && (r_state == IDLE || r_state == DONE);
  assign w_search = (r_state == SEARCH);
  assign w_zero   = (w_p == '0);
  assign w_tail   = (r_s >= r_nnz);
  assign w_lt     = (w_ci < w_c);
  assign w_eq     = (w_ci == w_c);
  assign w_full   = (r_nnz == IDX_W'(NNZ_MAX));
  assign w_fwd    = w_search && !w_zero && !w_tail && w_lt;
  assign w_adv_m  = w_search && !w_fwd;
  assign w_acc_en = w_search && !w_zero && !w_tail && w_eq;
  assign w_ins_en = w_search && !w_zero && (w_tail || (!w_lt && !w_eq));
  assign w_place  = w_ins_en && !w_full;
  assign w_m_last = ((r_m + I1) == r_mend);
  assign w_k_last = ((r_k + I1) == r_aend);

  csr_row_insert #(
    .DATA_W (DATA_W),
    .NNZ_MAX(NNZ_MAX),
    .IDX_W  (IDX_W)
  ) u_ins (
    .i_nv (r_nvc),
    .i_ci (r_cic),
    .i_pos(r_s),
    .i_val(w_p),
    .i_col(w_c),
    .o_nv (w_ins_nv),
    .o_ci (w_ins_ci)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE, DONE: w_nxt = w_accept ? ROW : IDLE;
      ROW:        w_nxt = (w_rp_lo == w_rp_hi) ? ROWEND : AELEM;
      AELEM: begin
        if (w_bp_lo == w_bp_hi) w_nxt = w_k_last ? ROWEND : AELEM;
        else                    w_nxt = SEARCH;
      end
      SEARCH: begin
        if (w_adv_m && w_m_last) w_nxt = w_k_last ? ROWEND : AELEM;
      end
      ROWEND:     w_nxt = ((r_r + I1) == r_nrows) ? DONE : ROW;
      default:    w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_nva <= '0; r_nvb <= '0; r_nvc <= '0;
      r_cia <= '0; r_cib <= '0; r_cic <= '0;
      r_rpa <= '0; r_rpb <= '0; r_rpc <= '0;
      r_nrows <= '0; r_r <= '0; r_k <= '0; r_aend <= '0;
      r_m <= '0; r_mend <= '0; r_s <= '0; r_nnz <= '0;
      r_ovf <= 1'b0;
`ifdef SPGEMM_SAT_EN
      r_sat <= 1'b0;
`endif
    end else if (w_accept) begin
      r_nva   <= nva_i;
      r_nvb   <= nvb_i;
      r_cia   <= cia_i;
      r_cib   <= cib_i;
      r_rpa   <= rpa_i;
      r_rpb   <= rpb_i;
      r_nrows <= n_rows_i;
      r_nvc   <= '0;
      r_cic   <= '0;
      r_rpc   <= '0;
      r_nnz   <= '0;
      r_ovf   <= 1'b0;
      r_r     <= '0;
`ifdef SPGEMM_SAT_EN
      r_sat   <= 1'b0;
`endif
    end else begin
      case (r_state)
        ROW: begin
          r_rpc[RW'(r_r)] <= r_nnz;
          r_k    <= w_rp_lo;
          r_aend <= w_rp_hi;
        end
        AELEM: begin
          r_m    <= w_bp_lo;
          r_mend <= w_bp_hi;
          r_s    <= r_rpc[RW'(r_r)];
          if (w_bp_lo == w_bp_hi) r_k <= r_k + I1;
        end
        SEARCH: begin
          if (w_acc_en) r_nvc[NW'(r_s)] <= w_acc;
          // A full C still accepts accumulates; only new entries are dropped.
          if (w_place) begin
            r_nvc <= w_ins_nv;
            r_cic <= w_ins_ci;
            r_nnz <= r_nnz + I1;
          end else if (w_ins_en) begin
            r_ovf <= 1'b1;
          end
          if (w_fwd || w_acc_en || w_place) r_s <= r_s + I1;
          if (w_adv_m) begin
            r_m <= r_m + I1;
            if (w_m_last) r_k <= r_k + I1;
          end
`ifdef SPGEMM_SAT_EN
          if ((w_adv_m && !w_zero && w_psat) || (w_acc_en && w_asat)) r_sat <= 1'b1;
`endif
        end
        ROWEND: begin
          r_r <= r_r + I1;
          if ((r_r + I1) == r_nrows) r_rpc[RW'(r_nrows)] <= r_nnz;
        end
        default: ;
      endcase
    end
  end

  assign busy_o     = (r_state == ROW) || (r_state == AELEM) ||
                      (r_state == SEARCH) || (r_state == ROWEND);
  assign done_o     = (r_state == DONE);
  assign nvc_o      = r_nvc;
  assign cic_o      = r_cic;
  assign rpc_o      = r_rpc;
  assign nnz_c_o    = r_nnz;
  assign overflow_o = r_ovf;
endmodule

// File: tb/tb_csr_spgemm_engine.sv
// Scoreboard bench for csr_spgemm_engine: dense reference product per run, compared on done_o.
module tb_csr_spgemm_engine;
  localparam int DW = 32, NNZ = 16, RM = 16, IW = 5;

  logic clk = 1'b0;
  logic rst_n, start;
  logic [IW-1:0]          n_rows;
  logic [NNZ*DW-1:0]      nva, nvb, nva_save;
  logic [NNZ*IW-1:0]      cia, cib;
  logic [(RM+1)*IW-1:0]   rpa, rpb;
  logic                   busy, done, ovf;
  logic [NNZ*DW-1:0]      nvc;
  logic [NNZ*IW-1:0]      cic;
  logic [(RM+1)*IW-1:0]   rpc;
  logic [IW-1:0]          nnz_c;

  always #5 clk = ~clk;

  csr_spgemm_engine dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .n_rows_i(n_rows),
    .nva_i(nva), .nvb_i(nvb), .cia_i(cia), .cib_i(cib), .rpa_i(rpa), .rpb_i(rpb),
    .busy_o(busy), .done_o(done), .nvc_o(nvc), .cic_o(cic), .rpc_o(rpc),
    .nnz_c_o(nnz_c), .overflow_o(ovf)
  );

  typedef struct {
    logic [NNZ*DW-1:0]    nvc;
    logic [NNZ*IW-1:0]    cic;
    logic [(RM+1)*IW-1:0] rpc;
    logic [IW-1:0]        nnz;
    logic                 ovf;
    bit                   arr;
  } exp_t;

  exp_t sbq[$];
  exp_t me, e;
  int n_tests = 0, n_fail = 0, n_done = 0, n_exp_done = 0;
  int unsigned ga[RM][RM], gb[RM][RM];
  int nr, nk, nc;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask

  task automatic clr_mats();
    for (int i = 0; i < RM; i++)
      for (int j = 0; j < RM; j++) begin
        ga[i][j] = 0;
        gb[i][j] = 0;
      end
  endtask

  // Build CSR operands from ga/gb and the expected C from a dense product.
  task automatic load(output exp_t x);
    logic [NNZ-1:0][DW-1:0] va, vb, ev;
    logic [NNZ-1:0][IW-1:0] ca, cb, ec;
    logic [RM:0][IW-1:0]    ra, rb, er;
    int cnt;
    int unsigned acc, p;
    bit hit;
    va = '0; vb = '0; ca = '0; cb = '0; ra = '0; rb = '0;
    ev = '0; ec = '0; er = '0;
    cnt = 0;
    for (int r = 0; r < nr; r++) begin
      ra[r] = IW'(cnt);
      for (int c = 0; c < nk; c++)
        if (ga[r][c] != 0) begin va[cnt] = ga[r][c]; ca[cnt] = IW'(c); cnt++; end
    end
    ra[nr] = IW'(cnt);
    cnt = 0;
    for (int r = 0; r < nk; r++) begin
      rb[r] = IW'(cnt);
      for (int c = 0; c < nc; c++)
        if (gb[r][c] != 0) begin vb[cnt] = gb[r][c]; cb[cnt] = IW'(c); cnt++; end
    end
    rb[nk] = IW'(cnt);
    cnt = 0;
    for (int r = 0; r < nr; r++) begin
      er[r] = IW'((cnt < NNZ) ? cnt : NNZ);
      for (int c = 0; c < nc; c++) begin
        acc = 0; hit = 0;
        for (int k = 0; k < nk; k++) begin
          p = ga[r][k] * gb[k][c];
          if (p != 0) begin acc += p; hit = 1; end
        end
        if (hit) begin
          if (cnt < NNZ) begin ev[cnt] = acc; ec[cnt] = IW'(c); end
          cnt++;
        end
      end
    end
    er[nr] = IW'((cnt < NNZ) ? cnt : NNZ);
    x.nvc = ev; x.cic = ec; x.rpc = er;
    x.nnz = IW'((cnt < NNZ) ? cnt : NNZ);
    x.ovf = (cnt > NNZ);
    x.arr = (cnt <= NNZ);
    nva = va; nvb = vb; cia = ca; cib = cb; rpa = ra; rpb = rb;
    n_rows = IW'(nr);
  endtask

  task automatic go(input exp_t x, input bit dup);
    bit got;
    sbq.push_back(x);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("busy_after_start", busy, 1);
    if (dup) begin
      repeat (2) @(negedge clk);
      nva_save = nva;
      nva = '1;
      start = 1'b1;
      @(negedge clk); start = 1'b0;
      nva = nva_save;
    end
    got = 0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1;
    end
    chk("done_seen", got, 1);
    if (got) n_exp_done++;
    else sbq.delete();
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      n_done++;
      chk("sb_pending", sbq.size() != 0, 1);
      if (sbq.size() != 0) begin
        me = sbq.pop_front();
        chk("nnz_c", nnz_c, me.nnz);
        chk("overflow", ovf, me.ovf);
        chk("rpc", rpc, me.rpc);
        chk("busy_at_done", busy, 0);
        if (me.arr) begin
          chk("nvc", nvc, me.nvc);
          chk("cic", cic, me.cic);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; n_rows = '0;
    nva = '0; nvb = '0; cia = '0; cib = '0; rpa = '0; rpb = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_nnz", nnz_c, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_nvc", nvc, 0);
    chk("rst_rpc", rpc, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // identity times upper-triangular
    clr_mats(); nr = 2; nk = 2; nc = 2;
    ga[0][0] = 1; ga[1][1] = 1;
    gb[0][0] = 1; gb[0][1] = 2; gb[1][1] = 3;
    load(e); go(e, 0);
    chk("t1_nvc", nvc[95:0], {32'd3, 32'd2, 32'd1});
    chk("t1_cic", cic[14:0], {5'd1, 5'd1, 5'd0});
    chk("t1_rpc", rpc[14:0], {5'd3, 5'd2, 5'd0});

    // reverse-order insert, empty second row
    clr_mats(); nr = 2; nk = 2; nc = 2;
    ga[0][0] = 1; ga[0][1] = 1;
    gb[0][1] = 5; gb[1][0] = 4;
    load(e); go(e, 0);
    chk("t2_nvc", nvc[63:0], {32'd5, 32'd4});
    chk("t2_rpc", rpc[14:0], {5'd2, 5'd2, 5'd0});

    // accumulate into one entry
    clr_mats(); nr = 1; nk = 2; nc = 2;
    ga[0][0] = 2; ga[0][1] = 3;
    gb[0][1] = 1; gb[1][1] = 1;
    load(e); go(e, 0);
    chk("t3_nvc0", nvc[31:0], 32'd5);
    chk("t3_cic0", cic[4:0], 5'd1);
    chk("t3_nnz", nnz_c, 5'd1);

    // dense 4x4 fills C exactly
    clr_mats(); nr = 4; nk = 4; nc = 4;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        ga[i][j] = i + j + 1;
        gb[i][j] = 2 * i + j + 1;
      end
    load(e); go(e, 0);
    chk("t4_nnz", nnz_c, 5'd16);
    chk("t4_ovf", ovf, 0);

    // fifth C column pushes past capacity
    gb[0][4] = 1; gb[3][3] = 0; nc = 5;
    load(e); go(e, 0);
    chk("t5_ovf", ovf, 1);
    chk("t5_nnz", nnz_c, 5'd16);

    // abort mid-run with reset
    load(e);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (8) @(negedge clk);
    chk("abort_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy0", busy, 0);
    chk("abort_done0", done, 0);
    chk("abort_nvc0", nvc, 0);
    chk("abort_cic0", cic, 0);
    chk("abort_rpc0", rpc, 0);
    chk("abort_nnz0", nnz_c, 0);
    chk("abort_ovf0", ovf, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    clr_mats(); nr = 2; nk = 2; nc = 2;
    ga[0][0] = 1; ga[1][1] = 1;
    gb[0][0] = 1; gb[0][1] = 2; gb[1][1] = 3;
    load(e); go(e, 0);
    chk("t6_nvc", nvc[95:0], {32'd3, 32'd2, 32'd1});

    // start pulsed while busy is ignored
    clr_mats(); nr = 2; nk = 2; nc = 2;
    ga[0][0] = 1; ga[0][1] = 1;
    gb[0][1] = 5; gb[1][0] = 4;
    load(e); go(e, 1);
    chk("t7_nvc", nvc[63:0], {32'd5, 32'd4});
    repeat (5) @(negedge clk);
    chk("done_count", n_done, n_exp_done);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
